// File: rtl/udc_pkg.sv
// Shared definitions for the up/down modulo counter (up_down_counter_mod).
// Holds the end-of-range mode encodings and the load clamping helper.
// Ports: none (package).
package udc_pkg;

  // End-of-range behaviour, selected by the SATURATE parameter.
  localparam int UDC_MODE_WRAP = 0;
  localparam int UDC_MODE_SAT  = 1;

  // Limits a load value to the top of the count range.
  function automatic int unsigned udc_clamp(input int unsigned value,
                                            input int unsigned max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/udc_next_val.sv
// Next-state logic for the up/down modulo counter: given the current count,
// direction and enable, produces the next count and the end-of-range event.
// Purely combinational; the registers live in up_down_counter_mod.
// Ports:
//   count      in  WIDTH  current registered count (always <= MAX_VAL)
//   up_down    in  1      1 = count up, 0 = count down
//   en         in  1      count enable; when low the count holds
//   next_count out WIDTH  count for the next cycle
//   evt        out 1      wrap (wrap mode) or blocked step (saturate mode)
module udc_next_val
  import udc_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int          SATURATE = UDC_MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_down,
  input  logic             en,
  output logic [WIDTH-1:0] next_count,
  output logic             evt
);

  localparam logic [WIDTH:0] MAX_EXT      = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] ONE_EXT      = (WIDTH+1)'(1);
  localparam bit             HOLD_AT_ENDS = (SATURATE == UDC_MODE_SAT);

  // One spare bit above the count keeps the increment of 2**WIDTH-1 and the
  // decrement of 0 visible instead of silently wrapping inside WIDTH bits.
  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;
  logic           past_max;
  logic           below_min;

  assign count_ext = {1'b0, count};
  assign inc       = count_ext + ONE_EXT;
  assign dec       = count_ext - ONE_EXT;
  assign past_max  = (inc > MAX_EXT);
  assign below_min = dec[WIDTH];  // borrow out: count was 0

  // NOTE: every output gets a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_count = count;
    evt        = 1'b0;
    if (en) begin
      if (up_down) begin
        if (past_max) begin
          evt = 1'b1;
          if (!HOLD_AT_ENDS) next_count = '0;
        end else begin
          next_count = inc[WIDTH-1:0];
        end
      end else begin
        if (below_min) begin
          evt = 1'b1;
          if (!HOLD_AT_ENDS) next_count = MAX_EXT[WIDTH-1:0];
        end else begin
          next_count = dec[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/up_down_counter_mod.sv
// Parametrised modulo up/down counter with synchronous load, count enable and
// wrap or saturate behaviour at the range ends. Counts over 0..MAX_VAL.
// Optional macro UDC_STICKY_EN adds sticky overflow/underflow flags.
// Ports:
//   clk        in  1      clock, all state updates on posedge
//   reset      in  1      synchronous active-high reset
//   en         in  1      count enable
//   load       in  1      synchronous load of data (beats en)
//   data       in  WIDTH  load value, clamped to MAX_VAL
//   up_down    in  1      1 = up, 0 = down
//   out        out WIDTH  registered count
//   at_max     out 1      registered, out == MAX_VAL
//   at_min     out 1      registered, out == 0
//   evt        out 1      one-cycle pulse on wrap / blocked step
//   clr_sticky in  1      (UDC_STICKY_EN) clear both sticky flags
//   ovf_sticky out 1      (UDC_STICKY_EN) set by an up-direction event
//   unf_sticky out 1      (UDC_STICKY_EN) set by a down-direction event
module up_down_counter_mod
  import udc_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int          SATURATE = UDC_MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             up_down,
  output logic [WIDTH-1:0] out,
  output logic             at_max,
  output logic             at_min,
  output logic             evt
`ifdef UDC_STICKY_EN
  ,
  input  logic             clr_sticky,
  output logic             ovf_sticky,
  output logic             unf_sticky
`endif
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] step_count;
  logic             step_evt;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_d;
  logic             evt_d;

  udc_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .SATURATE(SATURATE)
  ) u_next_val (
    .count     (out),
    .up_down   (up_down),
    .en        (en),
    .next_count(step_count),
    .evt       (step_evt)
  );

  assign load_val = WIDTH'(udc_clamp(32'(data), MAX_VAL));

  // Load overrides counting and never raises the event, even when clamped.
  assign count_d = load ? load_val : step_count;
  assign evt_d   = !load && step_evt;

  // Flags are computed from the next count so they line up with out.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out    <= '0;
      at_max <= (MAX_VAL == 0);
      at_min <= 1'b1;
      evt    <= 1'b0;
    end else begin
      out    <= count_d;
      at_max <= (count_d == MAX_W);
      at_min <= (count_d == '0);
      evt    <= evt_d;
    end
  end

`ifdef UDC_STICKY_EN
  // A new event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      if (evt_d && up_down)  ovf_sticky <= 1'b1;
      else if (clr_sticky)   ovf_sticky <= 1'b0;
      if (evt_d && !up_down) unf_sticky <= 1'b1;
      else if (clr_sticky)   unf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Testbench for up_down_counter_mod. Three instances share the stimulus:
//   w: WIDTH=4, MAX_VAL=9,   wrap
//   s: WIDTH=4, MAX_VAL=9,   saturate
//   f: WIDTH=8, MAX_VAL=255, wrap (full binary range)
// A behavioural model predicts every instance each cycle; predictions are
// queued at drive time and popped after the clock edge.
module tb_up_down_counter_mod;

  typedef struct packed {
    logic [7:0] cnt;
    logic       at_max;
    logic       at_min;
    logic       evt;
    logic       ovf;
    logic       unf;
  } exp_t;

  typedef logic [3*$bits(exp_t)-1:0] triple_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic       up_down;
  logic       clr_sticky;
  logic [7:0] data;

  logic [3:0] out_w, out_s;
  logic [7:0] out_f;
  logic       at_max_w, at_min_w, evt_w;
  logic       at_max_s, at_min_s, evt_s;
  logic       at_max_f, at_min_f, evt_f;
`ifdef UDC_STICKY_EN
  logic       ovf_w, unf_w, ovf_s, unf_s, ovf_f, unf_f;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  triple_t exp_q[$];

  // Model state and per-instance configuration.
  int unsigned m_cnt[3];
  bit          m_ovf[3];
  bit          m_unf[3];
  localparam int unsigned MV[3]    = '{9, 9, 255};
  localparam bit          SAT[3]   = '{1'b0, 1'b1, 1'b0};
  localparam int unsigned DMASK[3] = '{15, 15, 255};

  up_down_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .load(load), .data(data[3:0]),
    .up_down(up_down), .out(out_w), .at_max(at_max_w), .at_min(at_min_w),
    .evt(evt_w)
`ifdef UDC_STICKY_EN
    , .clr_sticky(clr_sticky), .ovf_sticky(ovf_w), .unf_sticky(unf_w)
`endif
  );

  up_down_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .load(load), .data(data[3:0]),
    .up_down(up_down), .out(out_s), .at_max(at_max_s), .at_min(at_min_s),
    .evt(evt_s)
`ifdef UDC_STICKY_EN
    , .clr_sticky(clr_sticky), .ovf_sticky(ovf_s), .unf_sticky(unf_s)
`endif
  );

  up_down_counter_mod #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0)) dut_f (
    .clk(clk), .reset(reset), .en(en), .load(load), .data(data),
    .up_down(up_down), .out(out_f), .at_max(at_max_f), .at_min(at_min_f),
    .evt(evt_f)
`ifdef UDC_STICKY_EN
    , .clr_sticky(clr_sticky), .ovf_sticky(ovf_f), .unf_sticky(unf_f)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  // Advance the model by one clock using the currently driven inputs.
  task automatic predict();
    exp_t e[3];
    for (int k = 0; k < 3; k++) begin
      int unsigned d;
      bit ev;
      d  = data & DMASK[k];
      ev = 1'b0;
      if (reset) begin
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
        m_unf[k] = 1'b0;
      end else begin
        if (load) begin
          m_cnt[k] = (d > MV[k]) ? MV[k] : d;
        end else if (en && up_down) begin
          if (m_cnt[k] == MV[k]) begin
            ev = 1'b1;
            if (!SAT[k]) m_cnt[k] = 0;
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end else if (en) begin
          if (m_cnt[k] == 0) begin
            ev = 1'b1;
            if (!SAT[k]) m_cnt[k] = MV[k];
          end else begin
            m_cnt[k] = m_cnt[k] - 1;
          end
        end
`ifdef UDC_STICKY_EN
        if (ev && up_down)       m_ovf[k] = 1'b1;
        else if (clr_sticky)     m_ovf[k] = 1'b0;
        if (ev && !up_down)      m_unf[k] = 1'b1;
        else if (clr_sticky)     m_unf[k] = 1'b0;
`endif
      end
      e[k].cnt    = 8'(m_cnt[k]);
      e[k].at_max = (m_cnt[k] == MV[k]);
      e[k].at_min = (m_cnt[k] == 0);
      e[k].evt    = ev;
      e[k].ovf    = m_ovf[k];
      e[k].unf    = m_unf[k];
    end
    exp_q.push_back({e[0], e[1], e[2]});
  endtask

  // Drive one cycle, queue the prediction, and return 1 ns after the edge.
  task automatic step(input bit r, input bit l, input bit e, input bit ud,
                      input logic [7:0] d, input bit c = 1'b0);
    reset      = r;
    load       = l;
    en         = e;
    up_down    = ud;
    data       = d;
    clr_sticky = c;
    predict();
    @(posedge clk);
    #1;
  endtask

  function automatic triple_t sample();
    exp_t a, b, c;
    a = '{cnt: {4'b0, out_w}, at_max: at_max_w, at_min: at_min_w, evt: evt_w,
          ovf: 1'b0, unf: 1'b0};
    b = '{cnt: {4'b0, out_s}, at_max: at_max_s, at_min: at_min_s, evt: evt_s,
          ovf: 1'b0, unf: 1'b0};
    c = '{cnt: out_f, at_max: at_max_f, at_min: at_min_f, evt: evt_f,
          ovf: 1'b0, unf: 1'b0};
`ifdef UDC_STICKY_EN
    a.ovf = ovf_w; a.unf = unf_w;
    b.ovf = ovf_s; b.unf = unf_s;
    c.ovf = ovf_f; c.unf = unf_f;
`endif
    return {a, b, c};
  endfunction

  task automatic test_reset();
    triple_t got, exp;
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 1, 1, 8'h00);
      got = sample(); exp = exp_q.pop_front(); n_assert++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h required %h", i, got, exp);
      end
    end
    n_assert++;
    if ({out_w, at_min_w, at_max_w, evt_w} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_flags: got out=%0d min=%b max=%b evt=%b required 0 1 0 0",
               out_w, at_min_w, at_max_w, evt_w);
    end
  endtask

  task automatic test_wrap_up();
    triple_t got, exp;
    for (int i = 0; i < 11; i++) begin
      step(0, 0, 1, 1, 8'h00);
      got = sample(); exp = exp_q.pop_front(); n_assert++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL wrap_up[%0d]: got %h required %h", i, got, exp);
      end
      n_assert++;
      if ({out_w, at_max_w, evt_w} !== {4'((i + 1) % 10), (i == 8), (i == 9)}) begin
        n_fail++;
        $display("FAIL wrap_up_seq[%0d]: got out=%0d max=%b evt=%b required %0d %b %b",
                 i, out_w, at_max_w, evt_w, (i + 1) % 10, (i == 8), (i == 9));
      end
    end
  endtask

  task automatic test_wrap_down();
    triple_t got, exp;
    step(0, 1, 0, 0, 8'd0);
    got = sample(); exp = exp_q.pop_front(); n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL wrap_down_load0: got %h required %h", got, exp);
    end
    step(0, 0, 1, 0, 8'd0);
    got = sample(); exp = exp_q.pop_front(); n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL wrap_down_step: got %h required %h", got, exp);
    end
    n_assert++;
    if ({out_w, evt_w, out_s, evt_s, out_f, evt_f} !==
        {4'd9, 1'b1, 4'd0, 1'b1, 8'd255, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_down_ends: got w=%0d/%b s=%0d/%b f=%0d/%b required 9/1 0/1 255/1",
               out_w, evt_w, out_s, evt_s, out_f, evt_f);
    end
    step(0, 1, 1, 1, 8'd15);
    got = sample(); exp = exp_q.pop_front(); n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL load_clamp: got %h required %h", got, exp);
    end
    n_assert++;
    if ({out_w, evt_w, at_max_w, out_f} !== {4'd9, 1'b0, 1'b1, 8'd15}) begin
      n_fail++;
      $display("FAIL load_clamp_val: got w=%0d evt=%b max=%b f=%0d required 9 0 1 15",
               out_w, evt_w, at_max_w, out_f);
    end
  endtask

  task automatic test_saturate();
    triple_t got, exp;
    step(0, 1, 0, 1, 8'd8);
    got = sample(); exp = exp_q.pop_front(); n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL sat_load8: got %h required %h", got, exp);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 8'd0);
      got = sample(); exp = exp_q.pop_front(); n_assert++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sat_up[%0d]: got %h required %h", i, got, exp);
      end
      n_assert++;
      if ({out_s, evt_s} !== {4'd9, (i != 0)}) begin
        n_fail++;
        $display("FAIL sat_hold[%0d]: got out=%0d evt=%b required 9 %b",
                 i, out_s, evt_s, (i != 0));
      end
    end
  endtask

  task automatic test_priority();
    triple_t got, exp;
    step(0, 1, 1, 1, 8'd5);
    got = sample(); exp = exp_q.pop_front(); n_assert++;
    if (got !== exp || out_w !== 4'd5) begin
      n_fail++;
      $display("FAIL load_over_en: got %h (w=%0d) required %h (w=5)", got, out_w, exp);
    end
    step(1, 0, 1, 1, 8'd0);
    got = sample(); exp = exp_q.pop_front(); n_assert++;
    if (got !== exp || out_w !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_over_en: got %h (w=%0d) required %h (w=0)", got, out_w, exp);
    end
    step(0, 0, 1, 1, 8'd0);
    got = sample(); exp = exp_q.pop_front(); n_assert++;
    if (got !== exp || out_w !== 4'd1) begin
      n_fail++;
      $display("FAIL resume_after_reset: got %h (w=%0d) required %h (w=1)", got, out_w, exp);
    end
    step(0, 0, 0, 0, 8'd7);
    got = sample(); exp = exp_q.pop_front(); n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL hold_en0: got %h required %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    triple_t got, exp;
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
      got = sample(); exp = exp_q.pop_front(); n_assert++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h required %h", i, got, exp);
      end
    end
  endtask

`ifdef UDC_STICKY_EN
  task automatic test_sticky();
    triple_t got, exp;
    step(1, 0, 0, 1, 8'd0);
    got = sample(); exp = exp_q.pop_front(); n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL sticky_reset: got %h required %h", got, exp);
    end
    step(0, 1, 0, 1, 8'd9);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 8'd0);
      got = sample(); exp = exp_q.pop_front(); n_assert++;
      if (got !== exp || {ovf_w, unf_w} !== 2'b10) begin
        n_fail++;
        $display("FAIL sticky_ovf[%0d]: got %h ovf=%b unf=%b required %h 1 0",
                 i, got, ovf_w, unf_w, exp);
      end
    end
    step(0, 1, 0, 1, 8'd0);
    void'(exp_q.pop_front());
    step(0, 0, 1, 0, 8'd0, 1'b1);
    got = sample(); exp = exp_q.pop_front(); n_assert++;
    if (got !== exp || {out_w, ovf_w, unf_w} !== {4'd9, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL sticky_clr_unf: got %h w=%0d ovf=%b unf=%b required %h 9 0 1",
               got, out_w, ovf_w, unf_w, exp);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; load = 1'b0; en = 1'b0; up_down = 1'b0;
    data = '0; clr_sticky = 1'b0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_back_to_back();
`ifdef UDC_STICKY_EN
    test_sticky();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
